riscv_decode_stage: RTL and testbench

Registered instruction-decode stage for the RV32I core. It turns a fetched 32-bit instruction into the 4-bit ALU operation select, operand-mux selects, register addresses, sign-extended immediate and writeback/memory controls. Results are held in one pipeline register with a valid/ready handshake. It sits between fetch and execute and is the producer of every ALU select code the execute stage consumes.

---
 rtl/riscv_pkg.sv | 67 ++++++
 rtl/riscv_imm_gen.sv | 24 ++
 rtl/riscv_decode_stage.sv | 195 +++++++++++++++++++
 tb/tb_riscv_decode_stage.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: ALU select codes, opcodes, writeback selects,
// immediate formats and the registered decode bundle.
package riscv_pkg;

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;
   localparam logic [3:0] ALU_SLL   = 4'b0010;
   localparam logic [3:0] ALU_SLT   = 4'b0011;
   localparam logic [3:0] ALU_SLTU  = 4'b0100;
   localparam logic [3:0] ALU_XOR   = 4'b0101;
   localparam logic [3:0] ALU_SRL   = 4'b0110;
   localparam logic [3:0] ALU_SRA   = 4'b0111;
   localparam logic [3:0] ALU_OR    = 4'b1000;
   localparam logic [3:0] ALU_AND   = 4'b1001;
   localparam logic [3:0] ALU_PASSB = 4'b1010;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

   typedef enum logic [2:0] {ImmNone, ImmI, ImmIsh, ImmS, ImmB, ImmU, ImmJ} imm_fmt_e;

   typedef struct packed {
      logic [3:0]  alusel;
      logic [31:0] imm;
      logic [4:0]  rs1_addr;
      logic [4:0]  rs2_addr;
      logic [4:0]  rd_addr;
      logic        asel;
      logic        bsel;
      logic        regwen;
      logic        memrw;
      logic        memrd;
      logic [1:0]  wbsel;
      logic        br_en;
      logic        brun;
      logic [2:0]  br_funct3;
      logic        illegal;
   } dec_bundle_t;

   // Base ALU operation for OP/OP-IMM; SUB/SRA selection is applied by the caller.
   function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3);
      logic [3:0] sel;
      case (funct3)
         3'b000:  sel = ALU_ADD;
         3'b001:  sel = ALU_SLL;
         3'b010:  sel = ALU_SLT;
         3'b011:  sel = ALU_SLTU;
         3'b100:  sel = ALU_XOR;
         3'b101:  sel = ALU_SRL;
         3'b110:  sel = ALU_OR;
         default: sel = ALU_AND;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/riscv_imm_gen.sv
// Combinational RV32I immediate builder; all formats sign-extend from instr[31],
// shift amounts are zero-extended.
module riscv_imm_gen
   import riscv_pkg::*;
(
   input  logic [31:0] instr,
   input  imm_fmt_e    fmt,
   output logic [31:0] imm
);

   always_comb begin
      imm = '0;
      case (fmt)
         ImmI:    imm = {{20{instr[31]}}, instr[31:20]};
         ImmIsh:  imm = {27'b0, instr[24:20]};
         ImmS:    imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         ImmB:    imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         ImmU:    imm = {instr[31:12], 12'b0};
         ImmJ:    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/riscv_decode_stage.sv
// Registered RV32I decode stage with valid/ready handshake and flush.
// Define DECODE_ILLEGAL_TRAP_EN to flag illegal instructions instead of decoding them as a NOP.
module riscv_decode_stage
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] pc,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [3:0]      alusel,
   output logic [31:0]     imm,
   output logic [4:0]      rs1_addr,
   output logic [4:0]      rs2_addr,
   output logic [4:0]      rd_addr,
   output logic            asel,
   output logic            bsel,
   output logic            regwen,
   output logic            memrw,
   output logic            memrd,
   output logic [1:0]      wbsel,
   output logic            br_en,
   output logic            brun,
   output logic [2:0]      br_funct3,
   output logic            illegal
);

   logic [6:0]  w_opc;
   logic [2:0]  w_f3;
   logic [6:0]  w_f7;
   logic        w_illegal;
   imm_fmt_e    w_fmt;
   logic [31:0] w_imm;
   dec_bundle_t w_ctrl;
   dec_bundle_t w_next;
   logic        w_load;

   logic            r_valid;
   logic [XLEN-1:0] r_pc;
   dec_bundle_t     r_bundle;

   assign w_opc = instr[6:0];
   assign w_f3  = instr[14:12];
   assign w_f7  = instr[31:25];

   always_comb begin
      w_ctrl           = '0;
      w_fmt            = ImmNone;
      w_illegal        = 1'b0;
      w_ctrl.rs1_addr  = instr[19:15];
      w_ctrl.rs2_addr  = instr[24:20];
      w_ctrl.rd_addr   = instr[11:7];
      w_ctrl.br_funct3 = w_f3;
      w_ctrl.brun      = w_f3[1];
      case (w_opc)
         OPC_OP: begin
            w_ctrl.alusel = alu_from_funct3(w_f3);
            if (w_f7[5] && w_f3 == 3'b000) w_ctrl.alusel = ALU_SUB;
            if (w_f7[5] && w_f3 == 3'b101) w_ctrl.alusel = ALU_SRA;
            w_ctrl.regwen = 1'b1;
            w_illegal = !(w_f7 == 7'h00 || (w_f7 == 7'h20 && (w_f3 == 3'b000 || w_f3 == 3'b101)));
         end
         OPC_OP_IMM: begin
            w_ctrl.alusel = alu_from_funct3(w_f3);
            if (w_f7[5] && w_f3 == 3'b101) w_ctrl.alusel = ALU_SRA;
            w_ctrl.bsel   = 1'b1;
            w_ctrl.regwen = 1'b1;
            w_fmt         = (w_f3 == 3'b001 || w_f3 == 3'b101) ? ImmIsh : ImmI;
            if (w_f3 == 3'b001) w_illegal = (w_f7 != 7'h00);
            if (w_f3 == 3'b101) w_illegal = !(w_f7 == 7'h00 || w_f7 == 7'h20);
         end
         OPC_LUI: begin
            w_ctrl.alusel = ALU_PASSB;
            w_ctrl.bsel   = 1'b1;
            w_ctrl.regwen = 1'b1;
            w_fmt         = ImmU;
         end
         OPC_AUIPC: begin
            w_ctrl.asel   = 1'b1;
            w_ctrl.bsel   = 1'b1;
            w_ctrl.regwen = 1'b1;
            w_fmt         = ImmU;
         end
         OPC_JAL: begin
            w_ctrl.asel   = 1'b1;
            w_ctrl.bsel   = 1'b1;
            w_ctrl.regwen = 1'b1;
            w_ctrl.wbsel  = WB_PC4;
            w_fmt         = ImmJ;
         end
         OPC_JALR: begin
            w_ctrl.bsel   = 1'b1;
            w_ctrl.regwen = 1'b1;
            w_ctrl.wbsel  = WB_PC4;
            w_fmt         = ImmI;
            w_illegal     = (w_f3 != 3'b000);
         end
         OPC_BRANCH: begin
            w_ctrl.asel  = 1'b1;
            w_ctrl.bsel  = 1'b1;
            w_ctrl.br_en = 1'b1;
            w_fmt        = ImmB;
            w_illegal    = (w_f3 == 3'b010 || w_f3 == 3'b011);
         end
         OPC_LOAD: begin
            w_ctrl.bsel   = 1'b1;
            w_ctrl.memrd  = 1'b1;
            w_ctrl.regwen = 1'b1;
            w_ctrl.wbsel  = WB_MEM;
            w_fmt         = ImmI;
            w_illegal     = (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111);
         end
         OPC_STORE: begin
            w_ctrl.bsel  = 1'b1;
            w_ctrl.memrw = 1'b1;
            w_fmt        = ImmS;
            w_illegal    = (w_f3 > 3'b010);
         end
         default: w_illegal = 1'b1;
      endcase
`ifdef DECODE_ILLEGAL_TRAP_EN
      if (w_illegal) begin
         w_ctrl.regwen  = 1'b0;
         w_ctrl.memrw   = 1'b0;
         w_ctrl.memrd   = 1'b0;
         w_ctrl.br_en   = 1'b0;
         w_ctrl.illegal = 1'b1;
      end
`else
      // Undecodable words become ADDI x0,x0,0 so execute sees a harmless bundle.
      if (w_illegal) begin
         w_ctrl      = '0;
         w_ctrl.bsel = 1'b1;
         w_fmt       = ImmNone;
      end
`endif
   end

   riscv_imm_gen u_imm_gen (
      .instr (instr),
      .fmt   (w_fmt),
      .imm   (w_imm)
   );

   always_comb begin
      w_next     = w_ctrl;
      w_next.imm = w_imm;
   end

   // A flush frees the stage, so fetch is never back-pressured while redirecting.
   assign in_ready = !r_valid || out_ready || flush;
   assign w_load   = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid  <= 1'b0;
         r_pc     <= '0;
         r_bundle <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_load) begin
         r_valid  <= 1'b1;
         r_pc     <= pc;
         r_bundle <= w_next;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign out_valid = r_valid;
   assign out_pc    = r_pc;
   assign alusel    = r_bundle.alusel;
   assign imm       = r_bundle.imm;
   assign rs1_addr  = r_bundle.rs1_addr;
   assign rs2_addr  = r_bundle.rs2_addr;
   assign rd_addr   = r_bundle.rd_addr;
   assign asel      = r_bundle.asel;
   assign bsel      = r_bundle.bsel;
   assign regwen    = r_bundle.regwen;
   assign memrw     = r_bundle.memrw;
   assign memrd     = r_bundle.memrd;
   assign wbsel     = r_bundle.wbsel;
   assign br_en     = r_bundle.br_en;
   assign brun      = r_bundle.brun;
   assign br_funct3 = r_bundle.br_funct3;
   assign illegal   = r_bundle.illegal;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Scoreboard bench for riscv_decode_stage: directed cases from the decode rules plus a
// randomized stream checked against a behavioural decode model.
module tb_riscv_decode_stage;

   typedef struct packed {
      logic [3:0]  alu;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        asel;
      logic        bsel;
      logic        regwen;
      logic        memrw;
      logic        memrd;
      logic [1:0]  wbsel;
      logic        br_en;
      logic        brun;
      logic [2:0]  f3;
      logic        illegal;
      logic [31:0] pc;
   } exp_t;

   localparam logic [3:0] F3_ALU [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
   localparam logic [6:0] OPCS [9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63,
                                       7'h03, 7'h23};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] instr = '0;
   logic [31:0] pc = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_pc;
   logic [3:0]  alusel;
   logic [31:0] imm;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr;
   logic        asel, bsel, regwen, memrw, memrd;
   logic [1:0]  wbsel;
   logic        br_en, brun;
   logic [2:0]  br_funct3;
   logic        illegal;

   int   total = 0;
   int   bad = 0;
   exp_t q[$];
   logic exp_valid = 1'b0;

   riscv_decode_stage #(.XLEN(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .instr     (instr),
      .pc        (pc),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .alusel    (alusel),
      .imm       (imm),
      .rs1_addr  (rs1_addr),
      .rs2_addr  (rs2_addr),
      .rd_addr   (rd_addr),
      .asel      (asel),
      .bsel      (bsel),
      .regwen    (regwen),
      .memrw     (memrw),
      .memrd     (memrd),
      .wbsel     (wbsel),
      .br_en     (br_en),
      .brun      (brun),
      .br_funct3 (br_funct3),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   // Decode rules written per instruction class, with immediates built arithmetically.
   function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] p);
      exp_t        e;
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic        ok;
      logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
      e     = '0;
      f7    = i[31:25];
      f3    = i[14:12];
      ok    = 1'b1;
      i_imm = 32'($signed(i) >>> 20);
      s_imm = {{21{i[31]}}, i[30:25], i[11:7]};
      b_imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      u_imm = i & 32'hFFFF_F000;
      j_imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      e.rs1 = i[19:15];
      e.rs2 = i[24:20];
      e.rd  = i[11:7];
      e.f3  = f3;
      e.brun = f3[1];
      e.pc  = p;
      case (i[6:0])
         7'h33: begin
            ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
            e.alu = F3_ALU[f3];
            if (f7[5] && f3 == 0) e.alu = 4'd1;
            if (f7[5] && f3 == 5) e.alu = 4'd7;
            e.regwen = 1;
         end
         7'h13: begin
            if (f3 == 1) ok = (f7 == 0);
            if (f3 == 5) ok = (f7 == 0) || (f7 == 7'h20);
            e.alu = (f3 == 5 && f7[5]) ? 4'd7 : F3_ALU[f3];
            e.imm = (f3 == 1 || f3 == 5) ? 32'(i[24:20]) : i_imm;
            e.bsel = 1; e.regwen = 1;
         end
         7'h37: begin e.alu = 4'd10; e.bsel = 1; e.regwen = 1; e.imm = u_imm; end
         7'h17: begin e.asel = 1; e.bsel = 1; e.regwen = 1; e.imm = u_imm; end
         7'h6f: begin e.asel = 1; e.bsel = 1; e.regwen = 1; e.wbsel = 2; e.imm = j_imm; end
         7'h67: begin ok = (f3 == 0); e.bsel = 1; e.regwen = 1; e.wbsel = 2; e.imm = i_imm; end
         7'h63: begin
            ok = !(f3 == 2 || f3 == 3);
            e.asel = 1; e.bsel = 1; e.br_en = 1; e.imm = b_imm;
         end
         7'h03: begin
            ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            e.bsel = 1; e.memrd = 1; e.regwen = 1; e.wbsel = 1; e.imm = i_imm;
         end
         7'h23: begin ok = (f3 <= 2); e.bsel = 1; e.memrw = 1; e.imm = s_imm; end
         default: ok = 1'b0;
      endcase
      if (!ok) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
         e.regwen = 0; e.memrw = 0; e.memrd = 0; e.br_en = 0; e.illegal = 1;
`else
         e = '0; e.bsel = 1; e.pc = p;
`endif
      end
      return e;
   endfunction

   function automatic logic [31:0] gen_instr();
      logic [31:0] r;
      int          sel;
      r   = $urandom;
      sel = $urandom_range(0, 10);
      if (sel < 9) begin
         r[6:0] = OPCS[sel];
         if ((sel == 0 || sel == 1) && $urandom_range(0, 3) != 0)
            r[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
      end
      return r;
   endfunction

   // One cycle of stimulus, applied just after the rising edge; pushes the expected bundle
   // when the transfer will happen at the next edge.
   task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] p,
                        input logic ordy, input logic fl, input logic rs);
      @(posedge clk);
      #1;
      in_valid  = iv;
      instr     = ins;
      pc        = p;
      out_ready = ordy;
      flush     = fl;
      rst       = rs;
      if (!rs && !fl && iv && (!exp_valid || ordy)) q.push_back(ref_decode(ins, p));
   endtask

   always @(negedge clk) begin
      exp_t g;
      logic acc;
      if (rst) begin
         exp_valid = 1'b0;
         q.delete();
      end else begin
         chk("out_valid", 128'(out_valid), 128'(exp_valid));
         chk("in_ready", 128'(in_ready), 128'(!exp_valid || out_ready || flush));
         if (exp_valid && out_valid) begin
            g = '{alu: alusel, imm: imm, rs1: rs1_addr, rs2: rs2_addr, rd: rd_addr, asel: asel,
                  bsel: bsel, regwen: regwen, memrw: memrw, memrd: memrd, wbsel: wbsel,
                  br_en: br_en, brun: brun, f3: br_funct3, illegal: illegal, pc: out_pc};
            if (q.size() == 0) chk("scoreboard_empty", 128'(1), 128'(0));
            else chk("bundle", 128'(g), 128'(q[0]));
         end
         if (flush) begin
            q.delete();
            exp_valid = 1'b0;
         end else begin
            acc = in_valid && (!exp_valid || out_ready);
            if (exp_valid && out_ready && q.size() != 0) void'(q.pop_front());
            exp_valid = acc || (exp_valid && !out_ready);
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_fields", 128'({alusel, imm, wbsel, regwen, bsel, illegal, out_pc}), 128'(0));

      // ADDI x1,x2,5
      drive(1, 32'h0051_0093, 32'h100, 1, 0, 0);
      drive(0, 0, 0, 1, 0, 0);
      @(negedge clk);
      chk("addi_valid", 128'(out_valid), 128'(1));
      chk("addi_alusel", 128'(alusel), 128'(0));
      chk("addi_imm", 128'(imm), 128'(5));
      chk("addi_bsel", 128'(bsel), 128'(1));
      chk("addi_rs1", 128'(rs1_addr), 128'(2));
      chk("addi_rd", 128'(rd_addr), 128'(1));
      chk("addi_regwen", 128'(regwen), 128'(1));

      // SUB x0,x1,x2 then SRAI x3,x4,2 then LUI x5,0x12345, back to back
      drive(1, 32'h4020_8033, 32'h104, 1, 0, 0);
      drive(1, 32'h4022_5193, 32'h108, 1, 0, 0);
      @(negedge clk);
      chk("sub_alusel", 128'(alusel), 128'(1));
      chk("sub_bsel", 128'(bsel), 128'(0));
      chk("sub_rs2", 128'(rs2_addr), 128'(2));
      drive(1, 32'h1234_52B7, 32'h10C, 1, 0, 0);
      @(negedge clk);
      chk("srai_alusel", 128'(alusel), 128'(7));
      chk("srai_imm", 128'(imm), 128'(2));
      drive(0, 0, 0, 1, 0, 0);
      @(negedge clk);
      chk("lui_alusel", 128'(alusel), 128'(10));
      chk("lui_imm", 128'(imm), 128'(32'h1234_5000));

      // Stall: out_ready low for three cycles while the next instruction waits
      drive(1, 32'h0051_0093, 32'h200, 1, 0, 0);
      for (int k = 0; k < 3; k++) begin
         drive(1, 32'h1234_52B7, 32'h204, 0, 0, 0);
         @(negedge clk);
         chk("stall_in_ready", 128'(in_ready), 128'(0));
         chk("stall_alusel", 128'(alusel), 128'(0));
      end
      drive(1, 32'h1234_52B7, 32'h204, 1, 0, 0);
      drive(0, 0, 0, 1, 0, 0);
      @(negedge clk);
      chk("release_pc", 128'(out_pc), 128'(32'h204));
      drive(0, 0, 0, 1, 0, 0);
      @(negedge clk);
      chk("release_once", 128'(out_valid), 128'(0));

      // Flush with a held bundle and a same-cycle incoming instruction
      drive(1, 32'h0051_0093, 32'h300, 1, 0, 0);
      drive(1, 32'h4020_8033, 32'h304, 0, 1, 0);
      drive(0, 0, 0, 1, 0, 0);
      @(negedge clk);
      chk("flush_valid", 128'(out_valid), 128'(0));

      // Reset in the middle of a stall
      drive(1, 32'h1234_52B7, 32'h400, 1, 0, 0);
      drive(1, 32'h0051_0093, 32'h404, 0, 0, 0);
      drive(1, 32'h0051_0093, 32'h404, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("midrst_valid", 128'(out_valid), 128'(0));
      chk("midrst_fields", 128'({alusel, imm, rd_addr, regwen, bsel, wbsel, out_pc}), 128'(0));

      // All-ones word is never decodable
      drive(1, 32'hFFFF_FFFF, 32'h500, 1, 0, 0);
      drive(0, 0, 0, 1, 0, 0);
      @(negedge clk);
`ifdef DECODE_ILLEGAL_TRAP_EN
      chk("ill_flag", 128'(illegal), 128'(1));
      chk("ill_wr", 128'({regwen, memrw}), 128'(0));
`else
      chk("ill_flag", 128'(illegal), 128'(0));
      chk("ill_nop", 128'({alusel, imm, regwen}), 128'(0));
`endif

      // Randomized stream
      for (int n = 0; n < 600; n++) begin
         drive($urandom_range(0, 3) != 0, gen_instr(), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
               $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, 0);
      end
      drive(0, 0, 0, 1, 0, 0);
      drive(0, 0, 0, 1, 0, 0);
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
